mem_ctrl: RTL

//  CPU-side memory controller; sole driver of the CPU's byte-serial bus (mem_a/mem_dout/mem_wr, mem_din).

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/mem_req_arb.sv | 28 ++
 rtl/mem_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the CPU memory path: access sizes, I/O region tag, controller states.
package riscv_pkg;

   localparam logic [1:0] SZ_B      = 2'b00;
   localparam logic [1:0] SZ_H      = 2'b01;
   localparam logic [1:0] SZ_W      = 2'b10;
   localparam logic [1:0] IO_REGION = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } mc_state_t;

   // Index of the final byte of an access; unknown size codes behave as a word.
   function automatic logic [1:0] last_idx(input logic [1:0] sz);
      case (sz)
         SZ_B:    return 2'd0;
         SZ_H:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_req_arb.sv
// Fixed-priority grant (load-store over fetch), combinational in the accept cycle;
// the winner is registered so the datapath knows who owns the transaction in flight.
module mem_req_arb (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic en_i,
   input  logic ls_vld_i,
   input  logic if_vld_i,
   output logic gnt_ls_o,
   output logic gnt_if_o,
   output logic own_ls_o
);

   logic own_ls_q;

   assign gnt_ls_o = en_i & ls_vld_i;
   assign gnt_if_o = en_i & if_vld_i & ~ls_vld_i;
   assign own_ls_o = own_ls_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         own_ls_q <= 1'b0;
      end else if (gnt_ls_o || gnt_if_o) begin
         own_ls_q <= gnt_ls_o;
      end
   end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial bus master: word fetches and 1/2/4-byte loads/stores, read done at T+N+2, write at T+N+1.
// Pauses on rdy_in=0, holds I/O writes while io_buffer_full; MEM_CTRL_IO_GAP_EN adds an idle cycle per I/O byte.
module mem_ctrl
   import riscv_pkg::*;
#(
   parameter logic [1:0] IO_HI  = IO_REGION,
   parameter int         ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              rdy_in,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full,
   input  logic              if_valid_in,
   input  logic [ADDR_W-1:0] if_addr_in,
   input  logic              if_cancel_in,
   output logic              if_done_out,
   output logic [31:0]       if_data_out,
   input  logic              ls_valid_in,
   input  logic              ls_wr_in,
   input  logic [1:0]        ls_size_in,
   input  logic [ADDR_W-1:0] ls_addr_in,
   input  logic [31:0]       ls_wdata_in,
   output logic              ls_done_out,
   output logic [31:0]       ls_rdata_out
);

`ifdef MEM_CTRL_IO_GAP_EN
   localparam bit IoGap = 1'b1;
`else
   localparam bit IoGap = 1'b0;
`endif

   function automatic logic is_io(input logic [ADDR_W-1:0] a);
      return a[17:16] == IO_HI;
   endfunction

   mc_state_t         state_q;
   logic [ADDR_W-1:0] base_q, mem_a_q;
   logic [7:0]        mem_dout_q;
   logic              mem_wr_q;
   logic [31:0]       wdata_q, data_q, if_data_q, ls_rdata_q;
   logic [1:0]        last_q, idx_q, cnt_q;
   logic              iss_done_q, smp_q, gap_q, if_done_q, ls_done_q;

   logic              arb_en, gnt_ls, gnt_if, own_ls, fetch_cancel;
   logic [ADDR_W-1:0] req_addr_d, a_nx_d, a_rw_d;
   logic [1:0]        idx_nx_d;
   logic [7:0]        byte_nx_d;
   logic [31:0]       rd_word_d;

   // No new accept while a done pulse is out: the requester still holds valid then.
   assign arb_en = (state_q == ST_IDLE) && rdy_in && !if_done_q && !ls_done_q;

   mem_req_arb u_arb (
      .clk_i    (clk_in),
      .rst_n_i  (rst_n_in),
      .en_i     (arb_en),
      .ls_vld_i (ls_valid_in),
      .if_vld_i (if_valid_in),
      .gnt_ls_o (gnt_ls),
      .gnt_if_o (gnt_if),
      .own_ls_o (own_ls)
   );

   assign req_addr_d   = gnt_ls ? ls_addr_in : if_addr_in;
   assign idx_nx_d     = idx_q + 2'd1;
   assign a_nx_d       = base_q + ADDR_W'(idx_nx_d);
   assign a_rw_d       = base_q + ADDR_W'(cnt_q);
   assign byte_nx_d    = 8'(wdata_q >> {idx_nx_d, 3'b000});
   assign rd_word_d    = data_q | (32'(mem_din) << {cnt_q, 3'b000});
   assign fetch_cancel = (state_q == ST_READ) && !own_ls && if_cancel_in;

   assign mem_a        = mem_a_q;
   assign mem_dout     = mem_dout_q;
   assign mem_wr       = mem_wr_q & rdy_in;
   assign if_done_out  = if_done_q;
   assign if_data_out  = if_data_q;
   assign ls_done_out  = ls_done_q;
   assign ls_rdata_out = ls_rdata_q;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         mem_wr_q   <= 1'b0;
         wdata_q    <= '0;
         data_q     <= '0;
         if_data_q  <= '0;
         ls_rdata_q <= '0;
         last_q     <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         iss_done_q <= 1'b0;
         smp_q      <= 1'b0;
         gap_q      <= 1'b0;
         if_done_q  <= 1'b0;
         ls_done_q  <= 1'b0;
      end else begin
         if_done_q <= 1'b0;
         ls_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (gnt_ls || gnt_if) begin
                  base_q     <= req_addr_d;
                  mem_a_q    <= req_addr_d;
                  last_q     <= gnt_ls ? last_idx(ls_size_in) : last_idx(SZ_W);
                  wdata_q    <= ls_wdata_in;
                  data_q     <= '0;
                  idx_q      <= '0;
                  cnt_q      <= '0;
                  iss_done_q <= 1'b0;
                  smp_q      <= 1'b0;
                  gap_q      <= 1'b0;
                  if (gnt_ls && ls_wr_in) begin
                     state_q    <= ST_WRITE;
                     mem_dout_q <= ls_wdata_in[7:0];
                     mem_wr_q   <= !(is_io(req_addr_d) && io_buffer_full);
                  end else begin
                     state_q <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (fetch_cancel) begin
                  state_q <= ST_IDLE;
                  mem_a_q <= '0;
               end else if (!rdy_in) begin
                  // Byte arriving now is dropped; rewind to the oldest unreceived byte for the restart.
                  smp_q      <= 1'b0;
                  idx_q      <= cnt_q;
                  iss_done_q <= 1'b0;
                  mem_a_q    <= a_rw_d;
               end else begin
                  smp_q <= !iss_done_q;
                  if (!iss_done_q) begin
                     if (idx_q == last_q) begin
                        iss_done_q <= 1'b1;
                     end else begin
                        idx_q   <= idx_nx_d;
                        mem_a_q <= a_nx_d;
                     end
                  end
                  if (smp_q) begin
                     data_q <= rd_word_d;
                     cnt_q  <= cnt_q + 2'd1;
                     if (cnt_q == last_q) begin
                        state_q <= ST_IDLE;
                        mem_a_q <= '0;
                        if (own_ls) begin
                           ls_done_q  <= 1'b1;
                           ls_rdata_q <= rd_word_d;
                        end else begin
                           if_done_q <= 1'b1;
                           if_data_q <= rd_word_d;
                        end
                     end
                  end
               end
            end
            ST_WRITE: begin
               if (rdy_in) begin
                  if (mem_wr_q && IoGap && is_io(mem_a_q)) begin
                     gap_q    <= 1'b1;
                     mem_wr_q <= 1'b0;
                  end else if (mem_wr_q || gap_q) begin
                     gap_q <= 1'b0;
                     if (idx_q == last_q) begin
                        state_q    <= ST_IDLE;
                        mem_a_q    <= '0;
                        mem_dout_q <= '0;
                        mem_wr_q   <= 1'b0;
                        ls_done_q  <= 1'b1;
                     end else begin
                        idx_q      <= idx_nx_d;
                        mem_a_q    <= a_nx_d;
                        mem_dout_q <= byte_nx_d;
                        mem_wr_q   <= !(is_io(a_nx_d) && io_buffer_full);
                     end
                  end else begin
                     mem_wr_q <= !(is_io(mem_a_q) && io_buffer_full);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
